// File: rtl/pc_ctrl.sv
// Fetch-stage PC sequencing controller: arbitrates redirects, stalls and halt,
// holds a redirect across an outstanding fetch, and keeps saturating perf counters.
module pc_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmem_req,
    input  logic             br_taken,
    input  logic             jump,
    input  logic             jr,
    input  logic             load_use,
    input  logic             halt,
    output logic             pc_en,
    output logic [2:0]       PCSrc,
    output logic             bubble,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [1:0] SRC_SEQ = 2'd0;
    localparam logic [1:0] SRC_BR  = 2'd1;
    localparam logic [1:0] SRC_J   = 2'd2;
    localparam logic [1:0] SRC_JR  = 2'd3;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        WAIT_FETCH = 2'd1,
        HALTED     = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       pend_q, pend_d;
    logic [CNT_W-1:0] stall_cnt_q, redirect_cnt_q;

    logic       dstall;
    logic       go;
    logic       redir_req;
    logic [1:0] req_src;
    logic [1:0] pend_eff;
    logic       redirect_apply;

    assign dstall    = dmem_req & ~dhit;
    assign go        = ihit & ~dstall;
    assign redir_req = br_taken | jr | jump;

    // Oldest instruction wins: EX branch over ID JR over ID J.
    always_comb begin
        req_src = SRC_SEQ;
        if (br_taken)  req_src = SRC_BR;
        else if (jr)   req_src = SRC_JR;
        else if (jump) req_src = SRC_J;
    end

    // A branch resolving behind a held J/JR is older, so it replaces the pending target.
    assign pend_eff = (br_taken && (pend_q != SRC_BR)) ? SRC_BR : pend_q;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            pend_q  <= SRC_SEQ;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            RUN: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (redir_req && !go) begin
                    state_d = WAIT_FETCH;
                    pend_d  = req_src;
                end
            end
            WAIT_FETCH: begin
                if (halt) begin
                    state_d = HALTED;
                    pend_d  = SRC_SEQ;
                end else if (go) begin
                    state_d = RUN;
                    pend_d  = SRC_SEQ;
                end else begin
                    pend_d  = pend_eff;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // Output logic; everything held low while reset is asserted
    always_comb begin
        pc_en          = 1'b0;
        PCSrc          = 3'd0;
        bubble         = 1'b0;
        flush_ifid     = 1'b0;
        flush_idex     = 1'b0;
        halted         = 1'b0;
        redirect_apply = 1'b0;
        if (!RST) begin
            case (state_q)
                RUN: begin
                    if (halt) begin
                        pc_en = 1'b0;
                    end else if (redir_req) begin
                        if (go) begin
                            pc_en          = 1'b1;
                            PCSrc          = 3'(req_src);
                            flush_ifid     = 1'b1;
                            flush_idex     = (req_src == SRC_BR);
                            redirect_apply = 1'b1;
                        end
                    end else if (load_use) begin
                        bubble = go;
                    end else begin
                        pc_en = go;
                    end
                end
                WAIT_FETCH: begin
                    PCSrc = 3'(pend_eff);
                    if (!halt && go) begin
                        pc_en          = 1'b1;
                        flush_ifid     = 1'b1;
                        flush_idex     = (pend_eff == SRC_BR);
                        redirect_apply = 1'b1;
                    end
                end
                HALTED:  halted = 1'b1;
                default: halted = 1'b0;
            endcase
        end
    end

    // Saturating performance counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (!pc_en && (state_q != HALTED) && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (redirect_apply && (redirect_cnt_q != '1))
                redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redirect_cnt_q;

    // Decoder guarantees J/JAL and JR are never presented together
    a_jump_jr_exclusive: assert property (@(posedge CLK) disable iff (RST) !(jump && jr));

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Sequencing controller for the fetch-stage program counter. Generates pc_en, PCSrc and bubble for the PC block.
- Arbitrates between competing redirects: taken branch resolved in EX, J/JAL and JR decoded in ID, load-use stalls and halt.
- A taken redirect is held while an instruction fetch is still outstanding (ihit low), then applied on the first cycle the fetch completes.
- Sits between the hazard/decode logic and the PC register. Also maintains saturating stall and redirect counters for performance analysis.

Parameters:
CNT_W, 16, width of the stall_cnt and redirect_cnt performance counters

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
ihit  input  1  instruction fetch completed this cycle
dhit  input  1  data memory access completed this cycle
dmem_req  input  1  MEM stage holds a load/store awaiting dhit
br_taken  input  1  EX stage resolved a taken branch
jump  input  1  ID stage holds J/JAL
jr  input  1  ID stage holds JR
load_use  input  1  ID instruction depends on a load currently in EX
halt  input  1  HALT has reached MEM
pc_en  output  1  PC register update enable
PCSrc  output  3  next-PC select: 0 SEQ (pc_plus_4), 1 BR, 2 J (immediate26), 3 JR (rdat1); 4-7 never driven
bubble  output  1  insert NOP into ID/EX this cycle
flush_ifid  output  1  squash IF/ID contents
flush_idex  output  1  squash ID/EX contents
halted  output  1  core halted
stall_cnt  output  CNT_W  cycles with pc_en=0 while not halted (saturating)
redirect_cnt  output  CNT_W  redirects applied (saturating)

Behaviour:
- State register: RUN, WAIT_FETCH, HALTED. Pending-redirect register pend: 2 bits, encoding matches PCSrc 1-3. All outputs are combinational from state, pend and inputs.
- Reset (RST=1 at edge):
  - state=RUN, pend=0, counters=0.
  - While RST is high: pc_en=0, PCSrc=0, bubble=0, flushes=0, halted=0.
  - Reset mid-WAIT_FETCH discards the pending redirect.
- dstall = dmem_req & ~dhit.
- Redirect request priority, oldest first: halt > br_taken > jr > jump. req_src is 1 for BR, 3 for JR, 2 for J.
- RUN:
  - halt=1: pc_en=0, next state HALTED.
  - Else a redirect is requested:
    - If ihit & ~dstall: PCSrc=req_src, pc_en=1, flush_ifid=1. flush_idex=1 only when the source is BR. redirect_cnt increments. Stay in RUN.
    - Else: pc_en=0, pend←req_src, next state WAIT_FETCH.
  - Else load_use=1: pc_en=0, bubble=1, PCSrc=0. The bubble is asserted only when ihit & ~dstall; otherwise it is a plain stall.
  - Else: PCSrc=0, pc_en=ihit & ~dstall.
- WAIT_FETCH:
  - PCSrc=pend at all times.
  - halt=1 → HALTED; pend is dropped.
  - br_taken=1 while pend is J/JR → pend upgraded to BR (the older instruction wins).
  - When ihit & ~dstall: pc_en=1, flushes as in RUN for the current pend, redirect_cnt increments, pend←0, next state RUN.
  - Otherwise pc_en=0. load_use is ignored in this state.
- HALTED:
  - pc_en=0, halted=1, PCSrc=0, all other outputs 0.
  - Exited only by RST.
- Simultaneous br_taken and load_use: the branch wins, bubble=0 (flush_idex covers the hazard).
- Simultaneous jump and jr: JR is selected (decoder contract says mutually exclusive; assertion flags violation).
- Counters:
  - stall_cnt increments every cycle with pc_en=0 and state≠HALTED and RST=0.
  - redirect_cnt increments on each applied redirect.
  - Both saturate at 2^CNT_W−1 and never wrap.

Test Plan:
- RST 2 cycles, then ihit=1 for 5 cycles, no hazards → pc_en=1 with PCSrc=0 on all 5 cycles; stall_cnt=0, redirect_cnt=0.
- br_taken=1 with ihit=1 → same cycle: PCSrc=1, pc_en=1, flush_ifid=1, flush_idex=1; redirect_cnt=1.
- jr=1 with ihit=0 for 3 cycles, then ihit=1 → WAIT_FETCH for 3 cycles with PCSrc=3, pc_en=0. On the 4th cycle: pc_en=1, flush_ifid=1, flush_idex=0. stall_cnt=3.
- jump=1 with ihit=0; next cycle br_taken=1; then ihit=1 → applied PCSrc=1 with both flushes asserted; redirect_cnt=1.
- load_use=1 with ihit=1 for 1 cycle → bubble=1, pc_en=0. load_use and br_taken together → bubble=0, PCSrc=1.
- halt=1 while dmem_req=1 and dhit=0 → HALTED next cycle; pc_en stays 0 and halted=1 for 10 cycles despite ihit=1. RST then clears halted and the counters.
- CNT_W=4 with 20 forced stall cycles → stall_cnt stops at 15.
